// File: rtl/gpio_input_filter.sv
// Pad input conditioning for the GPIO block: per-pin synchroniser, optional
// debounce filter with a shared stable-length threshold, and a one-cycle change pulse.
module gpio_input_filter #(
   parameter int N_GPIOS     = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic [N_GPIOS-1:0] pins_i,
   input  logic [N_GPIOS-1:0] filt_en_i,
   input  logic [CNT_W-1:0]   filt_len_i,
   output logic [N_GPIOS-1:0] val_o,
   output logic [N_GPIOS-1:0] edge_o
);

   logic [N_GPIOS-1:0] sync_q [SYNC_STAGES];
   logic [N_GPIOS-1:0] sync_s;
   logic [CNT_W-1:0]   cnt_q  [N_GPIOS];
   logic [CNT_W-1:0]   cnt_d  [N_GPIOS];
   logic [N_GPIOS-1:0] val_d;
   logic [CNT_W:0]     len_eff;

   // plain flop chain, nothing combinational between stages
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= pins_i;
         for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];

   // a zero length behaves like one so the filter never stalls
   assign len_eff = (filt_len_i == '0) ? (CNT_W+1)'(1) : {1'b0, filt_len_i};

   always_comb begin
      val_d = val_o;
      for (int i = 0; i < N_GPIOS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (!filt_en_i[i]) begin
            val_d[i] = sync_s[i];
            cnt_d[i] = '0;
         end else if (sync_s[i] == val_o[i]) begin
            cnt_d[i] = '0;
         end else if (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= len_eff) begin
            // widened compare so a full-scale count cannot wrap past the threshold
            val_d[i] = sync_s[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         val_o  <= '0;
         edge_o <= '0;
         for (int i = 0; i < N_GPIOS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         val_o  <= val_d;
         edge_o <= val_d ^ val_o;
         for (int i = 0; i < N_GPIOS; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

endmodule
